// File: rtl/bu_pkg.sv
// Shared types and constants for the execute-stage branch unit and its condition evaluator.
package bu_pkg;

    typedef enum logic [1:0] {
        BU_NONE   = 2'd0,
        BU_BRANCH = 2'd1,
        BU_JAL    = 2'd2,
        BU_JALR   = 2'd3
    } bu_op_t;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_REDIRECT = 1'b1
    } bu_state_t;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam int LINK_OFFSET = 4;

endpackage

// File: rtl/branch_cond.sv
// Combinational RV32I branch condition evaluator: (funct3, rs1, rs2) -> taken.
module branch_cond
    import bu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            taken
);

    always_comb begin
        taken = 1'b0;
        case (funct3)
            F3_BEQ:  taken = (rs1 == rs2);
            F3_BNE:  taken = (rs1 != rs2);
            F3_BLT:  taken = ($signed(rs1) <  $signed(rs2));
            F3_BGE:  taken = ($signed(rs1) >= $signed(rs2));
            F3_BLTU: taken = (rs1 <  rs2);
            F3_BGEU: taken = (rs1 >= rs2);
            // 010/011 are reserved encodings: quietly not taken
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_unit.sv
// Execute-stage control-transfer unit: evaluates BRANCH/JAL/JALR, registers the result
// toward writeback and holds a fetch redirect. RV_BU_RVC_EN relaxes alignment to 2 bytes.
//
// state       | meaning
// ST_RUN      | accepting micro-ops, no redirect outstanding
// ST_REDIRECT | redirect_valid held until fetch takes it; no new ops accepted
module branch_unit
    import bu_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int RESET_PC_ALIGN = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_op,
    input  logic [2:0]      in_funct3,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    input  logic [XLEN-1:0] in_imm,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_link,
    output logic            out_taken,
    output logic            out_misalign,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    input  logic            redirect_ready
);

`ifdef RV_BU_RVC_EN
    localparam int ALIGN_BITS = 1;
`else
    localparam int ALIGN_BITS = RESET_PC_ALIGN;
`endif
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'((64'd1 << ALIGN_BITS) - 64'd1);
    localparam logic [XLEN-1:0] JALR_MASK  = ~XLEN'(1);

    bu_state_t       state_q, state_d;
    logic            out_valid_q, out_valid_d;
    logic            out_taken_q, out_taken_d;
    logic            out_misalign_q, out_misalign_d;
    logic [XLEN-1:0] out_link_q, out_link_d;
    logic            redirect_valid_q, redirect_valid_d;
    logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;

    bu_op_t          op;
    logic            cond_taken;
    logic            taken;
    logic [XLEN-1:0] tgt_base;
    logic [XLEN-1:0] tgt_sum;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] link;
    logic            misalign;
    logic            accept;

    assign op = bu_op_t'(in_op);

    branch_cond #(.XLEN(XLEN)) u_cond (
        .funct3 (in_funct3),
        .rs1    (in_rs1),
        .rs2    (in_rs2),
        .taken  (cond_taken)
    );

    always_comb begin
        taken = 1'b0;
        case (op)
            BU_BRANCH: taken = cond_taken;
            BU_JAL:    taken = 1'b1;
            BU_JALR:   taken = 1'b1;
            default:   taken = 1'b0;
        endcase
    end

    // One shared adder: JALR adds to rs1, everything else to the pc
    assign tgt_base = (op == BU_JALR) ? in_rs1 : in_pc;
    assign tgt_sum  = tgt_base + in_imm;
    assign target   = (op == BU_JALR) ? (tgt_sum & JALR_MASK) : tgt_sum;
    assign link     = in_pc + XLEN'(LINK_OFFSET);
    assign misalign = taken && ((target & ALIGN_MASK) != '0);

    assign in_ready = (state_q == ST_RUN) && (!out_valid_q || out_ready) && !flush;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d          = state_q;
        out_valid_d      = out_valid_q;
        out_taken_d      = out_taken_q;
        out_misalign_d   = out_misalign_q;
        out_link_d       = out_link_q;
        redirect_valid_d = redirect_valid_q;
        redirect_pc_d    = redirect_pc_q;

        if (flush) begin
            out_valid_d      = 1'b0;
            redirect_valid_d = 1'b0;
            state_d          = ST_RUN;
        end else begin
            if (accept) begin
                out_valid_d    = 1'b1;
                out_taken_d    = taken;
                out_misalign_d = misalign;
                out_link_d     = link;
            end else if (out_ready) begin
                out_valid_d = 1'b0;
            end

            case (state_q)
                ST_RUN: begin
                    if (accept && taken && !misalign) begin
                        state_d          = ST_REDIRECT;
                        redirect_valid_d = 1'b1;
                        redirect_pc_d    = target;
                    end
                end
                ST_REDIRECT: begin
                    if (redirect_ready) begin
                        state_d          = ST_RUN;
                        redirect_valid_d = 1'b0;
                    end
                end
                default: begin
                    state_d          = ST_RUN;
                    redirect_valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= ST_RUN;
            out_valid_q      <= 1'b0;
            out_taken_q      <= 1'b0;
            out_misalign_q   <= 1'b0;
            out_link_q       <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            state_q          <= state_d;
            out_valid_q      <= out_valid_d;
            out_taken_q      <= out_taken_d;
            out_misalign_q   <= out_misalign_d;
            out_link_q       <= out_link_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

    assign out_valid      = out_valid_q;
    assign out_taken      = out_taken_q;
    assign out_misalign   = out_misalign_q;
    assign out_link       = out_link_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_branch_unit.sv
// Self-checking bench for branch_unit: behavioural reference model with per-cycle compare,
// directed scenarios with literal expectations, and a randomized phase. Honors RV_BU_RVC_EN.
module tb_branch_unit;
    import bu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_op = 2'd0;
    logic [2:0]  in_funct3 = 3'd0;
    logic [31:0] in_pc = '0, in_rs1 = '0, in_rs2 = '0, in_imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_link;
    logic        out_taken;
    logic        out_misalign;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready = 1'b1;

    logic [2:0]  bc_f3 = '0;
    logic [31:0] bc_rs1 = '0, bc_rs2 = '0;
    logic        bc_taken;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    branch_unit #(.XLEN(32), .RESET_PC_ALIGN(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_op          (in_op),
        .in_funct3      (in_funct3),
        .in_pc          (in_pc),
        .in_rs1         (in_rs1),
        .in_rs2         (in_rs2),
        .in_imm         (in_imm),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_link       (out_link),
        .out_taken      (out_taken),
        .out_misalign   (out_misalign),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .redirect_ready (redirect_ready)
    );

    branch_cond #(.XLEN(32)) u_cond_ut (
        .funct3 (bc_f3),
        .rs1    (bc_rs1),
        .rs2    (bc_rs2),
        .taken  (bc_taken)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference rules written straight from the ISA definitions
    function automatic logic ref_cond(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd4:    return $signed(a) < $signed(b);
            3'd5:    return $signed(a) >= $signed(b);
            3'd6:    return a < b;
            3'd7:    return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic ref_taken(input logic [1:0] op, input logic [2:0] f3,
                                       input logic [31:0] a, input logic [31:0] b);
        if (op == 2'd1) return ref_cond(f3, a, b);
        return op == 2'd2 || op == 2'd3;
    endfunction

    function automatic logic [31:0] ref_target(input logic [1:0] op, input logic [31:0] pc,
                                               input logic [31:0] a, input logic [31:0] imm);
        if (op == 2'd3) return ((a + imm) / 2) * 2;
        return pc + imm;
    endfunction

    function automatic logic ref_mis(input logic taken, input logic [31:0] tgt);
`ifdef RV_BU_RVC_EN
        return taken && (tgt % 2 != 0);
`else
        return taken && (tgt % 4 != 0);
`endif
    endfunction

    // Behavioural model: what writeback and fetch must see, updated once per cycle
    logic        m_ov = 0, m_taken = 0, m_mis = 0, m_rv = 0;
    logic [31:0] m_link = 0, m_rpc = 0;

    always @(negedge clk) begin
        logic exp_ready, acc, t, mis, rv_old;
        logic [31:0] tgt;
        if (!rst_n) begin
            m_ov = 0; m_taken = 0; m_mis = 0; m_rv = 0; m_link = 0; m_rpc = 0;
        end else begin
            chk("m_out_valid", {31'd0, out_valid}, {31'd0, m_ov});
            if (m_ov) begin
                chk("m_out_taken", {31'd0, out_taken}, {31'd0, m_taken});
                chk("m_out_misalign", {31'd0, out_misalign}, {31'd0, m_mis});
                chk("m_out_link", out_link, m_link);
            end
            chk("m_redirect_valid", {31'd0, redirect_valid}, {31'd0, m_rv});
            if (m_rv) chk("m_redirect_pc", redirect_pc, m_rpc);
            exp_ready = !m_rv && (!m_ov || out_ready) && !flush;
            chk("m_in_ready", {31'd0, in_ready}, {31'd0, exp_ready});

            acc    = in_valid && exp_ready;
            rv_old = m_rv;
            t      = ref_taken(in_op, in_funct3, in_rs1, in_rs2);
            tgt    = ref_target(in_op, in_pc, in_rs1, in_imm);
            mis    = ref_mis(t, tgt);
            if (flush) begin
                m_ov = 0;
                m_rv = 0;
            end else begin
                if (acc) begin
                    m_ov = 1; m_taken = t; m_mis = mis; m_link = in_pc + 32'd4;
                    if (t && !mis) begin
                        m_rv = 1; m_rpc = tgt;
                    end
                end else if (out_ready) begin
                    m_ov = 0;
                end
                if (rv_old && redirect_ready) m_rv = 0;
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [2:0] f3, input logic [31:0] pc,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm);
        int n = 0;
        @(posedge clk); #1;
        in_op = op; in_funct3 = f3; in_pc = pc; in_rs1 = a; in_rs2 = b; in_imm = imm;
        in_valid = 1'b1;
        #1;
        while (!in_ready && n < 50) begin
            @(posedge clk); #2;
            n++;
        end
        if (n >= 50) chk("issue_timeout", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_out_taken"}, {31'd0, out_taken}, 32'd0);
        chk({tag, "_out_misalign"}, {31'd0, out_misalign}, 32'd0);
        chk({tag, "_out_link"}, out_link, 32'd0);
        chk({tag, "_redirect_valid"}, {31'd0, redirect_valid}, 32'd0);
        chk({tag, "_redirect_pc"}, redirect_pc, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;

        // Standalone condition evaluator, including the literal signed/unsigned pins
        bc_f3 = 3'd5; bc_rs1 = 32'hFFFF_FFFF; bc_rs2 = 32'd1; #1;
        chk("bc_bge_neg", {31'd0, bc_taken}, 32'd0);
        bc_f3 = 3'd6; bc_rs1 = 32'd1; bc_rs2 = 32'hFFFF_FFFF; #1;
        chk("bc_bltu", {31'd0, bc_taken}, 32'd1);
        bc_f3 = 3'd4; #1;
        chk("bc_blt", {31'd0, bc_taken}, 32'd0);
        bc_f3 = 3'd2; bc_rs1 = 32'd3; bc_rs2 = 32'd3; #1;
        chk("bc_illegal", {31'd0, bc_taken}, 32'd0);
        for (int i = 0; i < 200; i++) begin
            bc_f3  = 3'($urandom);
            bc_rs1 = $urandom;
            bc_rs2 = ($urandom % 4 == 0) ? bc_rs1 : (($urandom % 2) ? $urandom : bc_rs1 ^ 32'h8000_0000);
            #1;
            chk("bc_random", {31'd0, bc_taken}, {31'd0, ref_cond(bc_f3, bc_rs1, bc_rs2)});
        end

        #3;
        chk_all_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // BGE with negative rs1: not taken; then rs1=5: redirect to 0x120
        issue(2'd1, 3'd5, 32'h100, 32'hFFFF_FFFF, 32'd1, 32'h20);
        @(negedge clk);
        chk("bge_neg_valid", {31'd0, out_valid}, 32'd1);
        chk("bge_neg_taken", {31'd0, out_taken}, 32'd0);
        chk("bge_neg_redirect", {31'd0, redirect_valid}, 32'd0);
        issue(2'd1, 3'd5, 32'h100, 32'd5, 32'd1, 32'h20);
        @(negedge clk);
        chk("bge_pos_taken", {31'd0, out_taken}, 32'd1);
        chk("bge_pos_redirect", {31'd0, redirect_valid}, 32'd1);
        chk("bge_pos_redirect_pc", redirect_pc, 32'h120);

        issue(2'd1, 3'd6, 32'h100, 32'd1, 32'hFFFF_FFFF, 32'h8);
        @(negedge clk);
        chk("bltu_taken", {31'd0, out_taken}, 32'd1);
        issue(2'd1, 3'd4, 32'h100, 32'd1, 32'hFFFF_FFFF, 32'h8);
        @(negedge clk);
        chk("blt_taken", {31'd0, out_taken}, 32'd0);

        issue(2'd3, 3'd0, 32'h200, 32'h1001, 32'd0, 32'd2);
        @(negedge clk);
        chk("jalr_link", out_link, 32'h204);
`ifdef RV_BU_RVC_EN
        chk("jalr_misalign", {31'd0, out_misalign}, 32'd0);
        chk("jalr_redirect", {31'd0, redirect_valid}, 32'd1);
        chk("jalr_redirect_pc", redirect_pc, 32'h1002);
`else
        chk("jalr_misalign", {31'd0, out_misalign}, 32'd1);
        chk("jalr_redirect", {31'd0, redirect_valid}, 32'd0);
`endif

        // Held redirect while fetch stalls
        redirect_ready = 1'b0;
        issue(2'd1, 3'd0, 32'h40, 32'd7, 32'd7, 32'h10);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_redirect_valid", {31'd0, redirect_valid}, 32'd1);
            chk("hold_redirect_pc", redirect_pc, 32'h50);
            chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        @(posedge clk); #1;
        redirect_ready = 1'b1;
        @(negedge clk);
        chk("hold_last_cycle", {31'd0, redirect_valid}, 32'd1);
        @(negedge clk);
        chk("release_redirect_valid", {31'd0, redirect_valid}, 32'd0);
        chk("release_in_ready", {31'd0, in_ready}, 32'd1);

        // Flush the cycle after a wrapping JAL
        out_ready = 1'b0;
        redirect_ready = 1'b0;
        issue(2'd2, 3'd0, 32'hFFFF_FFFC, 32'd0, 32'd0, 32'd8);
        @(negedge clk);
        chk("jal_wrap_redirect_pc", redirect_pc, 32'h4);
        chk("jal_wrap_redirect", {31'd0, redirect_valid}, 32'd1);
        chk("jal_wrap_out_valid", {31'd0, out_valid}, 32'd1);
        chk("jal_wrap_link", out_link, 32'h0);
        @(posedge clk); #1;
        flush = 1'b1;
        #1;
        chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_redirect", {31'd0, redirect_valid}, 32'd0);
        chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b1;
        redirect_ready = 1'b1;

        // Back-to-back not-taken BNE stream
        cnt = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            in_op = 2'd1; in_funct3 = 3'd1; in_pc = 32'h300 + 32'(4 * k);
            in_rs1 = 32'(k); in_rs2 = 32'(k); in_imm = 32'h40; in_valid = 1'b1;
            #1;
            chk("stream_in_ready", {31'd0, in_ready}, 32'd1);
            @(negedge clk);
            if (k > 0 && out_valid) cnt++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        if (out_valid) cnt++;
        chk("stream_results", 32'(cnt), 32'd4);
        chk("stream_last_link", out_link, 32'h310);

        // Reset pulse in the middle of a stream
        @(posedge clk); #1;
        in_valid = 1'b1; in_op = 2'd2; in_pc = 32'h500; in_imm = 32'h100;
        @(posedge clk); #1;
        in_op = 2'd1; in_funct3 = 3'd1; in_rs1 = 32'd9; in_rs2 = 32'd9;
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        in_valid = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Randomized traffic checked by the model every cycle
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            in_valid       = ($urandom % 4) != 0;
            in_op          = 2'($urandom);
            in_funct3      = 3'($urandom);
            in_pc          = ($urandom % 8 == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            in_rs1         = ($urandom % 3 == 0) ? 32'($urandom_range(0, 4)) - 32'd2 : $urandom;
            in_rs2         = ($urandom % 4 == 0) ? in_rs1 :
                             (($urandom % 3 == 0) ? 32'($urandom_range(0, 4)) - 32'd2 : $urandom);
            in_imm         = ($urandom % 2) ? 32'($signed(12'($urandom))) : $urandom;
            out_ready      = ($urandom % 4) != 0;
            redirect_ready = ($urandom % 3) != 0;
            flush          = ($urandom % 20) == 0;
        end
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1; redirect_ready = 1'b1;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
